// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
//
// Ports:
//   clka        clock, all state changes on rising edge
//   rst         asynchronous reset, active low
//   start       request a division (sampled in IDLE only)
//   signed_div  1 = DIV (two's complement), 0 = DIVU; sampled with start
//   cancel      pipeline flush; aborts any operation, wins over start
//   dividend    numerator, sampled with start
//   divisor     denominator, sampled with start
//   busy        state != IDLE
//   stall       combinational hold request to the pipeline
//   done        one-cycle pulse; quotient/remainder valid from this cycle
//   quotient    LO result, held until the next done
//   remainder   HI result, held until the next done
//
// Optional feature macro: DIV_EARLY_EXIT_EN -- when defined, an operation whose
// dividend magnitude is below the divisor magnitude skips the iteration and
// finishes one cycle after start. Results are identical either way.
module mips_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dmag;
  logic             qneg, rneg;

  // operand magnitudes, only meaningful in the start cycle
  logic             a_neg, b_neg, early;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_div & dividend[WIDTH-1];
  assign b_neg = signed_div & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

`ifdef DIV_EARLY_EXIT_EN
  assign early = (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  // One restoring step. The extra top bit keeps the borrow of the trial
  // subtraction; the most negative value's magnitude is 2^(WIDTH-1), which
  // is correct as an unsigned number, so overflow needs no special case.
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dmag};
  assign rem_nx  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx  = {quo[WIDTH-2:0], ~diff[WIDTH]};
  assign q_fin   = qneg ? -quo_nx : quo_nx;
  assign r_fin   = rneg ? -rem_nx : rem_nx;

  assign busy  = (state != S_IDLE);
  assign stall = (state == S_DIV) | ((state == S_IDLE) & start & ~cancel);

  // Results are written on the edge entering FINISH so they are already
  // valid while done is high.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dmag      <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            rem  <= '0;
            quo  <= a_mag;
            dmag <= b_mag;
            qneg <= a_neg ^ b_neg;
            rneg <= a_neg;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              done      <= 1'b1;
              cnt       <= '0;
              state     <= S_FINISH;
            end else if (early) begin
              quotient  <= '0;
              remainder <= dividend;
              done      <= 1'b1;
              cnt       <= '0;
              state     <= S_FINISH;
            end else begin
              cnt   <= CW'(WIDTH);
              state <= S_DIV;
            end
          end
          S_DIV: begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              quotient  <= q_fin;
              remainder <= r_fin;
              done      <= 1'b1;
              state     <= S_FINISH;
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit (WIDTH=32): directed cases from the
// block description plus randomized operations against an arithmetic model.
module tb_mips_div_unit;
  localparam int W = 32;

  logic         clka = 1'b0;
  logic         rst, start, signed_div, cancel;
  logic [W-1:0] dividend, divisor;
  logic         busy, stall, done;
  logic [W-1:0] quotient, remainder;

  int errs = 0, checks = 0;
  logic [W-1:0] prev_q = '0, prev_r = '0;

  mips_div_unit #(.WIDTH(W)) dut (
    .clka(clka), .rst(rst), .start(start), .signed_div(signed_div),
    .cancel(cancel), .dividend(dividend), .divisor(divisor),
    .busy(busy), .stall(stall), .done(done),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on 64-bit values.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    longint sa, sb, ma, mb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    lat = W + 1;
    if (b == '0) begin
      q = '1;
      r = a;
      lat = 1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
`ifdef DIV_EARLY_EXIT_EN
      if (ma < mb) lat = 1;
`endif
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] eq, er;
    int lat, n;
    bit got;
    model(a, b, s, eq, er, lat);
    dividend = a; divisor = b; signed_div = s; start = 1'b1;
    #1 chk("stall_start", stall, 1);
    @(posedge clka); #1 start = 1'b0;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clka);
      n++;
      if (done) got = 1;
      else chk("stall_busy", stall, 1);
    end
    if (!got) chk("timeout", 0, 1);
    else begin
      chk("latency", n, lat);
      chk("stall_done", stall, 0);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      prev_q = eq; prev_r = er;
    end
    @(negedge clka);
    chk("done_pulse", done, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clka);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    rst = 1'b1;
    @(negedge clka);

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h1, 1'b0);
    run_op(32'h1234, 32'h0, 1'b0);
    run_op(32'h1234, 32'h0, 1'b1);
    run_op(32'd3, 32'd9, 1'b0);

    // cancel wins over start in the same cycle
    dividend = 32'd50; divisor = 32'd5; signed_div = 1'b0;
    start = 1'b1; cancel = 1'b1;
    @(posedge clka); #1 start = 1'b0; cancel = 1'b0;
    @(negedge clka);
    chk("cancel_prio_busy", busy, 0);

    // cancel mid-operation
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clka); #1 start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(negedge clka);
      chk("cancel_pre_done", done, 0);
    end
    @(negedge clka);
    cancel = 1'b1;
    @(posedge clka); #1 cancel = 1'b0;
    @(negedge clka);
    chk("cancel_busy", busy, 0);
    chk("cancel_done", done, 0);
    chk("cancel_q_held", quotient, prev_q);
    chk("cancel_r_held", remainder, prev_r);
    run_op(32'd100, 32'd7, 1'b0);

    // reset in the middle of an operation
    dividend = 32'd999; divisor = 32'd4; start = 1'b1;
    @(posedge clka); #1 start = 1'b0;
    repeat (5) @(negedge clka);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    @(negedge clka);
    rst = 1'b1;
    prev_q = '0; prev_r = '0;
    @(negedge clka);

    for (int k = 0; k < 30; k++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mips_div_unit.md
# mips_div_unit

Parametrised multi-cycle integer divider for the pipelined MIPS core. It implements DIV/DIVU for the execute stage and returns a quotient and remainder for the HI/LO registers. It holds the pipeline through a stall output while it iterates. It replaces single-cycle combinational division with a radix-2 restoring iteration of WIDTH cycles, and adds cancel-on-flush and defined divide-by-zero behaviour.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.

Ports:
- clka  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted at 0).
- start  input  1  request a division; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- cancel  input  1  flush from pipeline; aborts any operation in progress.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  state != IDLE.
- stall  output  1  combinational hold request to pipeline.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  LO value; registered and held until next done.
- remainder  output  WIDTH  HI value; registered and held until next done.

## Operation
- States: IDLE, DIV, FINISH.
- IDLE, start=1, cancel=0:
  - Latch operands and signed_div.
  - Convert signed operands to magnitudes; record the quotient sign (operand signs differ) and the remainder sign (dividend sign).
  - Load iteration counter = WIDTH. Go to DIV; if divisor == 0, go straight to FINISH.
- DIV: each cycle shift {rem,quo} left by 1, trial-subtract the divisor magnitude from the upper part, and set the quotient LSB if the difference is non-negative. Decrement the counter. At zero, go to FINISH.
- FINISH: apply signs (negate quotient and/or remainder as recorded), write the quotient/remainder registers, assert done, return to IDLE.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified, either mode).
- Signed overflow (−2^(WIDTH−1) / −1): quotient = 0x8000…0, remainder = 0. This falls out of the unsigned-magnitude path and needs no special case.
- Remainder arithmetic uses WIDTH+1 bits internally so the trial subtraction never loses the borrow.
- cancel=1 in any state: go to IDLE at the next edge. No done pulse; quotient/remainder keep their previous values. cancel has priority over start in the same cycle.
- start while busy: ignored; no queueing.
- stall = (state==DIV) | (state==IDLE & start & ~cancel). stall is 0 in FINISH, so the pipeline advances in the done cycle and captures the results.

## Timing
- Reset values: state IDLE, busy 0, stall 0, done 0, quotient 0, remainder 0, counter 0.
- Normal latency: start sampled at edge 0 → DIV for WIDTH cycles → FINISH. done is high during cycle WIDTH+1 after the start cycle (33 cycles for WIDTH=32).
- Divide-by-zero latency: done is high in cycle 1 after the start cycle.
- done is high for exactly one cycle. A new start is accepted in the cycle after done (back-to-back issue).
- Reset asserted mid-operation: immediate return to reset values; no done.

## Configuration
- DIV_EARLY_EXIT_EN:
  - Defined: in the start cycle, if dividend magnitude < divisor magnitude, skip DIV and go to FINISH. Result is quotient 0, remainder = dividend; done at cycle 1.
  - Undefined: all non-zero-divisor operations take the full WIDTH+1 cycles.
  - Results are identical either way; only latency differs.

## Test plan
- WIDTH=32, unsigned 100/7 → quotient 14, remainder 2. done at cycle 33, stall high cycles 0..32, stall low in the done cycle.
- Signed −7/2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0, dividend 0x1234 → done at cycle 1, quotient 0xFFFFFFFF, remainder 0x1234.
- Cancel at cycle 10 of a 100/7 operation → IDLE next edge, no done, outputs keep prior results. A start in the following cycle completes normally.
- Reset low at cycle 5 of a busy operation → all outputs 0 immediately. With DIV_EARLY_EXIT_EN defined, 3/9 → done at cycle 1, quotient 0, remainder 3.
